rv32_mem_arbiter: RTL and testbench

Shares one single-port, one-cycle-read-latency word memory between the RV32 core's instruction-fetch port and its load/store data port. Data accesses take priority. A starvation counter forces an instruction-fetch grant after a bounded wait. The block sits between the core's `instr_*`/`mem_*` buses and the memory array, and replaces direct dual-port access.

---
 rtl/rv32_bus_pkg.sv | 19 +
 rtl/rv32_starve_cnt.sv | 30 +++
 rtl/rv32_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_bus_pkg.sv
// rtl/rv32_bus_pkg.sv - shared types and defaults for the rv32 memory arbiter
package rv32_bus_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 32;
  localparam int unsigned MAX_WAIT_DEFAULT  = 4;
  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DATA_W            = 32;

  // Who owns the memory response arriving in the current cycle.
  typedef enum logic [2:0] {
    OWN_NONE    = 3'd0,
    OWN_IF      = 3'd1,
    OWN_DATA_RD = 3'd2,
    OWN_DATA_WR = 3'd3,
    OWN_ERR_IF  = 3'd4,
    OWN_ERR_D   = 3'd5
  } owner_t;

endpackage

// File: rtl/rv32_starve_cnt.sv
// rtl/rv32_starve_cnt.sv - saturating count of consecutive denied fetch cycles
module rv32_starve_cnt
  import rv32_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic gnt,
  output logic expired
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!req || gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign expired = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - shares one single-port word memory between fetch and load/store
module rv32_mem_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  logic   if_gnt;
  logic   d_gnt;
  logic   if_expired;
  logic   if_in_range;
  logic   d_in_range;
  owner_t owner;
  owner_t owner_d;
  logic   err_store;

  assign if_in_range = (if_addr_i < MEM_LIMIT);
  assign d_in_range  = (d_addr_i < MEM_LIMIT);

  rv32_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (if_req_i),
    .gnt     (if_gnt),
    .expired (if_expired)
  );

  // Data wins unless fetch has waited long enough; reset masks every grant.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst_i) begin
      if (if_req_i && if_expired) begin
        if_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end else if (if_req_i) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt) begin
      mem_en_o    = d_in_range;
      mem_we_o    = d_in_range & d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt) begin
      mem_en_o    = if_in_range;
      mem_addr_o  = if_addr_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (d_gnt) begin
      if (!d_in_range) begin
        owner_d = OWN_ERR_D;
      end else if (d_we_i) begin
        owner_d = OWN_DATA_WR;
      end else begin
        owner_d = OWN_DATA_RD;
      end
    end else if (if_gnt) begin
      owner_d = if_in_range ? OWN_IF : OWN_ERR_IF;
    end
  end

  // err_store separates an out-of-range store (error only) from a load (rvalid + error).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner     <= OWN_NONE;
      err_store <= 1'b0;
    end else begin
      owner     <= owner_d;
      err_store <= d_gnt & d_we_i;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_err_o     = 1'b0;
    d_rdata_o   = '0;
    if (!rst_i) begin
      unique case (owner)
        OWN_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i;
        end
        OWN_ERR_IF: begin
          if_rvalid_o = 1'b1;
          if_err_o    = 1'b1;
        end
        OWN_DATA_RD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_rdata_i;
        end
        OWN_ERR_D: begin
          d_rvalid_o = ~err_store;
          d_err_o    = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - directed self-checking bench for rv32_mem_arbiter
module tb_rv32_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;

  int vec;
  int errs;

  logic [31:0] mem_model [0:31];

  rv32_mem_arbiter #(
    .MEM_WORDS (32),
    .MAX_WAIT  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .d_err_o     (d_err_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: read returns the pre-write contents.
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem_model[mem_addr_o[4:0]] <= mem_wdata_o;
      mem_rdata <= mem_model[mem_addr_o[4:0]];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [135:0] outs;
    rst = 1'b1;
    tick;
    tick;
    outs = {if_gnt_o, if_rvalid_o, if_err_o, d_gnt_o, d_rvalid_o, d_err_o, mem_en_o, mem_we_o,
            mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o};
    vec++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL reset_idle: outputs=%h required 0", outs);
    end
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd16;
    #1;
    vec++;
    if ({d_gnt_o, mem_en_o, if_gnt_o} !== 3'b110) begin
      errs++;
      $display("FAIL reset_first_grant: gnt/en/if_gnt=%b required 110", {d_gnt_o, mem_en_o, if_gnt_o});
    end
    rst = 1'b1;
    #1;
    outs = {if_gnt_o, if_rvalid_o, if_err_o, d_gnt_o, d_rvalid_o, d_err_o, mem_en_o, mem_we_o,
            mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o};
    vec++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL reset_gated_with_req: outputs=%h required 0", outs);
    end
    tick;
    d_req = 1'b0;
    rst = 1'b0;
    #1;
    vec++;
    if ({d_rvalid_o, d_err_o, if_rvalid_o} !== 3'b000) begin
      errs++;
      $display("FAIL reset_dropped_load: rvalid/err/if_rvalid=%b required 000", {d_rvalid_o, d_err_o, if_rvalid_o});
    end
    tick;
    vec++;
    if (d_rvalid_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_late_rvalid: d_rvalid=%b required 0", d_rvalid_o);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] words [3];
    words[0] = 32'h0400_2083;
    words[1] = 32'h0000_0013;
    words[2] = 32'h0010_0093;
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'(i); d_wdata = words[i];
      #1;
      vec++;
      if ({d_gnt_o, mem_en_o, mem_we_o} !== 3'b111 || mem_addr_o !== 32'(i) || mem_wdata_o !== words[i]) begin
        errs++;
        $display("FAIL preload_store[%0d]: gnt/en/we=%b addr=%h wdata=%h required 111 %h %h",
                 i, {d_gnt_o, mem_en_o, mem_we_o}, mem_addr_o, mem_wdata_o, i, words[i]);
      end
      tick;
    end
    d_req = 1'b0; d_we = 1'b0;
    #1;
    vec++;
    if ({d_rvalid_o, d_err_o} !== 2'b00) begin
      errs++;
      $display("FAIL store_no_response: rvalid/err=%b required 00", {d_rvalid_o, d_err_o});
    end
    if_req = 1'b1; if_addr = 32'd0;
    #1;
    vec++;
    if ({if_gnt_o, d_gnt_o, mem_en_o, mem_we_o} !== 4'b1010 || mem_addr_o !== 32'd0) begin
      errs++;
      $display("FAIL fetch_grant: if_gnt/d_gnt/en/we=%b addr=%h required 1010 0",
               {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o}, mem_addr_o);
    end
    tick;
    if_req = 1'b0;
    #1;
    vec++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0400_2083 || if_err_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
      errs++;
      $display("FAIL fetch_data: rvalid=%b rdata=%h err=%b d_rvalid=%b required 1 04002083 0 0",
               if_rvalid_o, if_rdata_o, if_err_o, d_rvalid_o);
    end
    tick;
    vec++;
    if ({if_rvalid_o, mem_en_o} !== 2'b00 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
      errs++;
      $display("FAIL idle_after_fetch: rvalid/en=%b addr=%h wdata=%h required 00 0 0",
               {if_rvalid_o, mem_en_o}, mem_addr_o, mem_wdata_o);
    end
  endtask

  task automatic test_store_load;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd16; d_wdata = 32'h3F;
    #1;
    vec++;
    if ({d_gnt_o, mem_en_o, mem_we_o} !== 3'b111 || mem_wdata_o !== 32'h3F) begin
      errs++;
      $display("FAIL store16: gnt/en/we=%b wdata=%h required 111 3f", {d_gnt_o, mem_en_o, mem_we_o}, mem_wdata_o);
    end
    tick;
    d_we = 1'b0;
    #1;
    vec++;
    if ({d_gnt_o, mem_we_o, d_rvalid_o} !== 3'b100) begin
      errs++;
      $display("FAIL load16_grant: gnt/we/rvalid=%b required 100", {d_gnt_o, mem_we_o, d_rvalid_o});
    end
    tick;
    d_we = 1'b1; d_wdata = 32'h55;
    #1;
    vec++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h3F || d_err_o !== 1'b0 || if_rdata_o !== 32'd0) begin
      errs++;
      $display("FAIL load16_data: rvalid=%b rdata=%h err=%b if_rdata=%h required 1 3f 0 0",
               d_rvalid_o, d_rdata_o, d_err_o, if_rdata_o);
    end
    tick;
    d_we = 1'b0;
    tick;
    d_req = 1'b0;
    #1;
    vec++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h55) begin
      errs++;
      $display("FAIL load_after_store: rvalid=%b rdata=%h required 1 55", d_rvalid_o, d_rdata_o);
    end
    tick;
  endtask

  task automatic test_load_store_order;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd16;
    tick;
    d_we = 1'b1; d_wdata = 32'hA5;
    #1;
    vec++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h55 || mem_we_o !== 1'b1) begin
      errs++;
      $display("FAIL load_before_store: rvalid=%b rdata=%h we=%b required 1 55 1", d_rvalid_o, d_rdata_o, mem_we_o);
    end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    int  nf;
    int  nd;
    logic exp_f;
    logic prev_f;
    nf = 0; nd = 0; prev_f = 1'b0;
    if_req = 1'b1; if_addr = 32'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    for (int c = 1; c <= 15; c++) begin
      #1;
      exp_f = (c % 5 == 0);
      vec++;
      if (if_gnt_o !== exp_f || d_gnt_o !== !exp_f) begin
        errs++;
        $display("FAIL contention_grant[%0d]: if_gnt=%b d_gnt=%b required %b %b", c, if_gnt_o, d_gnt_o, exp_f, !exp_f);
      end
      if (c > 1) begin
        vec++;
        if (prev_f ? (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13 || d_rvalid_o !== 1'b0)
                   : (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h0010_0093 || if_rvalid_o !== 1'b0)) begin
          errs++;
          $display("FAIL contention_resp[%0d]: if_rv=%b if_rd=%h d_rv=%b d_rd=%h fetch_owner=%b",
                   c, if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o, prev_f);
        end
      end
      if (if_gnt_o === 1'b1) nf++;
      if (d_gnt_o === 1'b1) nd++;
      prev_f = exp_f;
      tick;
    end
    if_req = 1'b0; d_req = 1'b0;
    #1;
    vec++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13) begin
      errs++;
      $display("FAIL contention_last_resp: rvalid=%b rdata=%h required 1 13", if_rvalid_o, if_rdata_o);
    end
    vec++;
    if (nf !== 3 || nd !== 12) begin
      errs++;
      $display("FAIL contention_counts: fetch=%0d data=%0d required 3 12", nf, nd);
    end
    tick;
  endtask

  task automatic test_out_of_range;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd32;
    #1;
    vec++;
    if ({d_gnt_o, mem_en_o, mem_we_o} !== 3'b100) begin
      errs++;
      $display("FAIL oor_load_grant: gnt/en/we=%b required 100", {d_gnt_o, mem_en_o, mem_we_o});
    end
    tick;
    d_we = 1'b1; d_addr = 32'd40; d_wdata = 32'hDEAD;
    #1;
    vec++;
    if ({d_rvalid_o, d_err_o} !== 2'b11 || d_rdata_o !== 32'd0) begin
      errs++;
      $display("FAIL oor_load_resp: rvalid/err=%b rdata=%h required 11 0", {d_rvalid_o, d_err_o}, d_rdata_o);
    end
    vec++;
    if ({d_gnt_o, mem_en_o, mem_we_o} !== 3'b100) begin
      errs++;
      $display("FAIL oor_store_grant: gnt/en/we=%b required 100", {d_gnt_o, mem_en_o, mem_we_o});
    end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    if_req = 1'b1; if_addr = 32'd100;
    #1;
    vec++;
    if ({d_rvalid_o, d_err_o} !== 2'b01) begin
      errs++;
      $display("FAIL oor_store_resp: rvalid/err=%b required 01", {d_rvalid_o, d_err_o});
    end
    vec++;
    if ({if_gnt_o, mem_en_o} !== 2'b10) begin
      errs++;
      $display("FAIL oor_fetch_grant: gnt/en=%b required 10", {if_gnt_o, mem_en_o});
    end
    tick;
    if_req = 1'b0;
    #1;
    vec++;
    if ({if_rvalid_o, if_err_o, d_err_o} !== 3'b110 || if_rdata_o !== 32'd0) begin
      errs++;
      $display("FAIL oor_fetch_resp: rvalid/err/d_err=%b rdata=%h required 110 0",
               {if_rvalid_o, if_err_o, d_err_o}, if_rdata_o);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words[0] = 32'h0400_2083;
    words[1] = 32'h0000_0013;
    words[2] = 32'h0010_0093;
    for (int i = 0; i < 4; i++) begin
      if_req = (i < 3);
      if_addr = 32'(i);
      #1;
      if (i < 3) begin
        vec++;
        if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'(i)) begin
          errs++;
          $display("FAIL b2b_grant[%0d]: gnt=%b addr=%h required 1 %h", i, if_gnt_o, mem_addr_o, i);
        end
      end
      if (i > 0) begin
        vec++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== words[i-1]) begin
          errs++;
          $display("FAIL b2b_data[%0d]: rvalid=%b rdata=%h required 1 %h", i - 1, if_rvalid_o, if_rdata_o, words[i-1]);
        end
      end
      tick;
    end
    if_req = 1'b0;
    #1;
    vec++;
    if (if_rvalid_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end: rvalid=%b required 0", if_rvalid_o);
    end
  endtask

  initial begin
    vec = 0; errs = 0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset;
    test_fetch;
    test_store_load;
    test_load_store_order;
    test_contention;
    test_out_of_range;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
